// File: rtl/udma_spim_cmd_pkg.sv
// Shared definitions for the SPIM uDMA command encoder: opcodes, field
// positions, request record and encoder FSM states.
package udma_spim_cmd_pkg;

  localparam logic [3:0] CMD_UCA = 4'hD;
  localparam logic [3:0] CMD_UCS = 4'hE;

  localparam int CMD_OP_MSB    = 31;
  localparam int CMD_OP_LSB    = 28;
  localparam int CMD_TXRXN_BIT = 27;
  localparam int CMD_DS_MSB    = 26;
  localparam int CMD_DS_LSB    = 25;

  // Address/size fields are stored at their widest legal width; narrower
  // instances zero-extend into them so the payload bits above the
  // configured width stay 0 in the emitted word.
  localparam int REQ_FLD_W = 25;

  typedef struct packed {
    logic                 txrxn;
    logic                 noaddr;
    logic [REQ_FLD_W-1:0] addr;
    logic [REQ_FLD_W-1:0] size;
    logic [1:0]           datasize;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UCA  = 2'd1,
    ST_UCS  = 2'd2
  } state_e;

  // Build a command word; use_addr selects address payload (UCA) vs size (UCS).
  function automatic logic [31:0] enc_word(input logic [3:0] op, input req_t r,
                                           input logic use_addr);
    logic [31:0] w;
    w = '0;
    w[CMD_OP_MSB:CMD_OP_LSB] = op;
    w[CMD_TXRXN_BIT]         = r.txrxn;
    w[CMD_DS_MSB:CMD_DS_LSB] = r.datasize;
    w[REQ_FLD_W-1:0]         = use_addr ? r.addr : r.size;
    return w;
  endfunction

endpackage

// File: rtl/udma_spim_req_fifo.sv
// Small synchronous FIFO holding queued requests behind the in-flight one.
module udma_spim_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr] <= data_i;
  end

  // Pointer and occupancy tracking; flush discards everything queued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + 1'b1;
      if (pop_i)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = r_mem[r_rptr];
  assign count_o = r_cnt;
  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);

endmodule

// File: rtl/udma_spim_cmd_encoder.sv
// Turns SPIM channel-transfer requests into UCA/UCS command words on a
// registered valid/ready stream, with a small queue of pending requests.
module udma_spim_cmd_encoder
  import udma_spim_cmd_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int REQ_DEPTH      = 2,
  localparam int QW = $clog2(REQ_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_txrxn_i,
  input  logic                      req_noaddr_i,
  input  logic [L2_AWIDTH_NOAL-1:0] req_addr_i,
  input  logic [TRANS_SIZE-1:0]     req_size_i,
  input  logic [1:0]                req_datasize_i,
  input  logic                      flush_i,
  output logic [31:0]               udma_cmd_o,
  output logic                      udma_cmd_valid_o,
  input  logic                      udma_cmd_ready_i,
  output logic                      busy_o,
  output logic [QW-1:0]             queued_o
);

  localparam int RW = $bits(req_t);

  state_e        r_state, w_state_nxt;
  logic          r_valid, w_valid_nxt;
  logic [31:0]   r_cmd, w_cmd_nxt;
  req_t          r_cur, w_cur_nxt;
  logic          r_busy;

  req_t          w_in, w_head, w_new;
  logic [RW-1:0] w_head_raw;
  logic [QW-1:0] w_cnt;
  logic [QW-1:0] w_cnt_nxt;
  logic          w_full, w_empty;
  logic          w_req_hs, w_out_hs, w_reload, w_fifo_avail;
  logic          w_pop, w_push, w_bypass;

  // Zero-extend the incoming request into the wide request record.
  always_comb begin
    w_in          = '0;
    w_in.txrxn    = req_txrxn_i;
    w_in.noaddr   = req_noaddr_i;
    w_in.addr[L2_AWIDTH_NOAL-1:0] = req_addr_i;
    w_in.size[TRANS_SIZE-1:0]     = req_size_i;
    w_in.datasize = req_datasize_i;
  end

  assign req_ready_o  = ~w_full & ~flush_i;
  assign w_req_hs     = req_valid_i & req_ready_o;
  assign w_out_hs     = r_valid & udma_cmd_ready_i;
  assign w_reload     = ~r_valid | w_out_hs;
  // A flush must not hand a queued request to the slot on the same edge.
  assign w_fifo_avail = ~w_empty & ~flush_i;
  assign w_head       = req_t'(w_head_raw);
  assign w_new        = w_fifo_avail ? w_head : w_in;

  // Slot reload: finish the current pair, else start the queue head, else
  // bypass the incoming request straight into the slot, else go idle.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_cmd_nxt   = r_cmd;
    w_cur_nxt   = r_cur;
    w_pop       = 1'b0;
    w_bypass    = 1'b0;
    if (w_reload) begin
      if (r_state == ST_UCA) begin
        w_state_nxt = ST_UCS;
        w_valid_nxt = 1'b1;
        w_cmd_nxt   = enc_word(CMD_UCS, r_cur, 1'b0);
      end else if (w_fifo_avail || w_req_hs) begin
        w_pop       = w_fifo_avail;
        w_bypass    = ~w_fifo_avail;
        w_cur_nxt   = w_new;
        w_valid_nxt = 1'b1;
        if (w_new.noaddr) begin
          w_state_nxt = ST_UCS;
          w_cmd_nxt   = enc_word(CMD_UCS, w_new, 1'b0);
        end else begin
          w_state_nxt = ST_UCA;
          w_cmd_nxt   = enc_word(CMD_UCA, w_new, 1'b1);
        end
      end else begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
      end
    end
  end

  assign w_push    = w_req_hs & ~w_bypass;
  assign w_cnt_nxt = flush_i ? '0 : (w_cnt + QW'(w_push) - QW'(w_pop));

  udma_spim_req_fifo #(
    .WIDTH (RW),
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_in),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .data_o  (w_head_raw),
    .count_o (w_cnt),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Output slot, in-flight request and busy flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_cmd   <= '0;
      r_cur   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_valid_nxt;
      r_cmd   <= w_cmd_nxt;
      r_cur   <= w_cur_nxt;
      r_busy  <= w_valid_nxt | (w_cnt_nxt != '0);
    end
  end

  assign udma_cmd_o       = r_cmd;
  assign udma_cmd_valid_o = r_valid;
  assign busy_o           = r_busy;
  assign queued_o         = w_cnt;

endmodule
